// File: rtl/axi_dma_w_burst.sv
// Write DMA: coalesces contiguous databus writes into AXI4 INCR bursts.
// A burst is buffered in FILL, then issued as one AW, cnt W beats and one B.
`timescale 1ns/1ps
module axi_dma_w_burst #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 30,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 32,
    parameter int AXI_ID  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  ready,
    input  logic                  flush,
    output logic                  idle,
    output logic                  error,
    input  logic                  err_clr,
    output logic                  m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic                  m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int CNT_W = $clog2(MAX_LEN) + 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [31:0]       idle_cnt_q, idle_cnt_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic              bready_q, bready_d;
    logic              error_q, error_d;
    logic              idle_q, idle_d;

    logic [DATA_W-1:0] buf_data_q [MAX_LEN];
    logic [BYTES-1:0]  buf_strb_q [MAX_LEN];

    logic [ADDR_W-1:0] addr_al_s, next_addr_s, end_addr_s;
    logic [CNT_W-1:0]  cnt_after_s;
    logic              ready_s, accept_s, close_s, timeout_s, cross_s;
    logic              buf_we_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              err_set_s;
    logic              unused_s;

    // Acceptance of databus beats and burst-closing conditions.
    always_comb begin
        addr_al_s   = addr & ~ADDR_W'(BYTES - 1);
        next_addr_s = base_q + (ADDR_W'(cnt_q) << OFF);
        if (state_q == ST_IDLE) begin
            ready_s = valid && rst;
        end else if (state_q == ST_FILL) begin
            ready_s = valid && (addr_al_s == next_addr_s) && (cnt_q < CNT_W'(MAX_LEN))
                      && (base_q[ADDR_W-1:12] == next_addr_s[ADDR_W-1:12]);
        end else begin
            ready_s = 1'b0;
        end
        accept_s    = ready_s;
        cnt_after_s = (accept_s && state_q == ST_FILL) ? cnt_q + CNT_W'(1) : cnt_q;
        end_addr_s  = base_q + (ADDR_W'(cnt_after_s) << OFF);
        cross_s     = (base_q[ADDR_W-1:12] != end_addr_s[ADDR_W-1:12]);
        timeout_s   = (TIMEOUT != 0) && !accept_s && (idle_cnt_q + 32'd1 == 32'(TIMEOUT));
        close_s     = (cnt_after_s == CNT_W'(MAX_LEN)) || cross_s || (valid && !ready_s)
                      || timeout_s || flush;
    end

    // Next-state and output-register computation for the burst FSM.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        idle_cnt_d = idle_cnt_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        bready_d   = bready_q;
        buf_we_s   = 1'b0;
        wr_idx_s   = IDX_W'(cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    base_d     = addr_al_s;
                    cnt_d      = CNT_W'(1);
                    buf_we_s   = 1'b1;
                    wr_idx_s   = {IDX_W{1'b0}};
                    idle_cnt_d = 32'd0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    buf_we_s   = 1'b1;
                    cnt_d      = cnt_after_s;
                    idle_cnt_d = 32'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
                if (close_s) begin
                    state_d    = ST_ADDR;
                    awvalid_d  = 1'b1;
                    awaddr_d   = base_q;
                    awlen_d    = 8'(cnt_after_s - CNT_W'(1));
                    idle_cnt_d = 32'd0;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    idx_d     = {CNT_W{1'b0}};
                    wlast_d   = (cnt_q == CNT_W'(1));
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_axi_wready && wlast_q) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    bready_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (m_axi_wready) begin
                    idx_d   = idx_q + CNT_W'(1);
                    wlast_d = (idx_q + CNT_W'(2) == cnt_q);
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_set_s = (state_q == ST_RESP) && m_axi_bvalid && m_axi_bresp[1];
        error_d   = err_set_s ? 1'b1 : (err_clr ? 1'b0 : error_q);
        idle_d    = (state_d == ST_IDLE);
    end

    // FSM and AXI control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= {ADDR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= {CNT_W{1'b0}};
            idle_cnt_q <= 32'd0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= {ADDR_W{1'b0}};
            awlen_q    <= 8'd0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            error_q    <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            idle_cnt_q <= idle_cnt_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            error_q    <= error_d;
            idle_q     <= idle_d;
        end
    end

    // Burst buffer; holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_data_q[wr_idx_s] <= wdata;
            buf_strb_q[wr_idx_s] <= wstrb;
        end
    end

    assign unused_s      = ^{m_axi_bid, m_axi_bresp[0]};
    assign ready         = ready_s;
    assign idle          = idle_q;
    assign error         = error_q;
    assign m_axi_awid    = 1'(AXI_ID);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(OFF);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = buf_data_q[idx_q[IDX_W-1:0]];
    assign m_axi_wstrb   = buf_strb_q[idx_q[IDX_W-1:0]];
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_dma_w_burst.sv
// Bench for axi_dma_w_burst: random and directed beat groups, an AXI slave
// model and a scoreboard checking bursts, beats and final memory contents.
`timescale 1ns/1ps
module tb_axi_dma_w_burst;
    localparam int DW = 256;
    localparam int AW = 30;
    localparam int ML = 16;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst, valid, flush, err_clr, ready, idle, error;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic awid, awlock, awvalid, awready, wlast, wvalid, wready, bid, bvalid, bready;
    logic [AW-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, bresp;
    logic [3:0] awcache, awqos;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;

    axi_dma_w_burst #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML), .TIMEOUT(TO), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .flush(flush), .idle(idle), .error(error), .err_clr(err_clr),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; int len; } burst_t;
    burst_t        bq[$];
    logic [DW-1:0] wq_d[$];
    logic [31:0]   wq_s[$];
    logic [DW-1:0] mem_exp[int];
    logic [DW-1:0] mem_act[int];
    logic [AW-1:0] g_a[$];
    logic [DW-1:0] g_d[$];
    logic [31:0]   g_s[$];

    int checks = 0;
    int errors = 0;
    int aw_delay = 0;
    int w_mode = 0;
    logic [1:0] bresp_next = 2'b00;
    logic b_pend = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [31:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < DW / 8; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Reference: a burst is a maximal run of consecutive beats, at most ML long,
    // never leaving the 4 KB page of its first beat.
    task automatic model_group();
        logic [AW-1:0] st;
        int n;
        burst_t b;
        logic [DW-1:0] old;
        st = '0;
        n = 0;
        for (int i = 0; i < g_a.size(); i++) begin
            if (n > 0 && g_a[i] == st + AW'(n * 32) && n < ML && g_a[i][AW-1:12] == st[AW-1:12]) begin
                n++;
            end else begin
                if (n > 0) begin b.a = st; b.len = n; bq.push_back(b); end
                st = g_a[i];
                n = 1;
            end
            wq_d.push_back(g_d[i]);
            wq_s.push_back(g_s[i]);
            old = mem_exp.exists(int'(g_a[i])) ? mem_exp[int'(g_a[i])] : '0;
            mem_exp[int'(g_a[i])] = merge(old, g_d[i], g_s[i]);
        end
        if (n > 0) begin b.a = st; b.len = n; bq.push_back(b); end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with valid still high.
    task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] s);
        logic r;
        int k;
        k = 0;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        forever begin
            #1 r = ready;
            @(posedge clk);
            if (r) break;
            k++;
            if (k > 4000) begin chk("beat_accept_timeout", 0, 1); break; end
        end
        @(negedge clk);
    endtask

    task automatic drive_range(input int from, input int to, input int max_gap);
        for (int i = from; i < to; i++) begin
            if (i > 0 && max_gap > 0) begin
                int gap;
                gap = $urandom_range(0, max_gap);
                if (gap > 0) begin valid = 1'b0; repeat (gap) @(negedge clk); end
            end
            send_beat(g_a[i], g_d[i], g_s[i]);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(idle && bq.size() == 0 && wq_d.size() == 0 && !b_pend)) begin
            @(negedge clk); #2;
            k++;
            if (k > 3000) begin chk("idle_wait_timeout", 0, 1); break; end
        end
    endtask

    task automatic end_timeout();
        valid = 1'b0;
        wait_idle();
    endtask

    task automatic end_flush();
        valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();
    endtask

    task automatic new_group(input logic [AW-1:0] base, input int n);
        g_a.delete(); g_d.delete(); g_s.delete();
        for (int i = 0; i < n; i++) begin
            g_a.push_back(base + AW'(i * 32));
            g_d.push_back(rnd_data());
            g_s.push_back($urandom);
        end
    endtask

    // AXI slave model plus monitor/scoreboard: drives ready/B at each negedge,
    // then samples the handshakes that will occur on the following posedge.
    initial begin : slave
        int aw_wait, rem, beat_i;
        logic [AW-1:0] cur_addr;
        logic [1:0] bresp_cur;
        logic prev_stall;
        logic [DW-1:0] prev_wdata, old;
        burst_t b;
        aw_wait = 0; rem = 0; beat_i = 0; cur_addr = '0; bresp_cur = 2'b00;
        prev_stall = 1'b0; prev_wdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; b_pend = 1'b0;
                continue;
            end
            if (awvalid) begin
                awready = (aw_wait >= aw_delay);
                if (!awready) aw_wait++;
            end else begin
                awready = 1'b0; aw_wait = 0;
            end
            if (w_mode == 0) wready = 1'b1;
            else if (w_mode == 1) wready = 1'($urandom_range(0, 1));
            else wready = ~wready;
            bvalid = b_pend;
            bresp = b_pend ? bresp_cur : 2'b00;
            #1;
            if (awvalid && wvalid) chk("aw_w_overlap", 1, 0);
            if (prev_stall && wvalid) chk("wdata_stable", m_wdata, prev_wdata);
            prev_stall = wvalid && !wready;
            prev_wdata = m_wdata;
            if (awvalid && awready) begin
                if (bq.size() == 0) begin
                    chk("unexpected_aw", 1, 0);
                end else begin
                    b = bq.pop_front();
                    chk("awaddr", DW'(awaddr), DW'(b.a));
                    chk("awlen", DW'(awlen), DW'(b.len - 1));
                    rem = b.len; beat_i = 0; cur_addr = awaddr;
                    bresp_cur = bresp_next; bresp_next = 2'b00;
                end
            end
            if (wvalid && wready) begin
                if (wq_d.size() == 0) begin
                    chk("unexpected_w", 1, 0);
                end else begin
                    chk("wdata", m_wdata, wq_d.pop_front());
                    chk("wstrb", DW'(m_wstrb), DW'(wq_s.pop_front()));
                    chk("wlast", DW'(wlast), DW'(rem == 1));
                    old = mem_act.exists(int'(cur_addr + AW'(beat_i * 32))) ?
                          mem_act[int'(cur_addr + AW'(beat_i * 32))] : '0;
                    mem_act[int'(cur_addr + AW'(beat_i * 32))] = merge(old, m_wdata, m_wstrb);
                    beat_i++; rem--;
                end
                if (wlast) b_pend = 1'b1;
            end
            if (bvalid && bready) b_pend = 1'b0;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        logic [AW-1:0] a;
        rst = 1'b0; valid = 1'b0; flush = 1'b0; err_clr = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", DW'(awvalid), 0);
        chk("rst_wvalid", DW'(wvalid), 0);
        chk("rst_bready", DW'(bready), 0);
        chk("rst_wlast", DW'(wlast), 0);
        chk("rst_awaddr", DW'(awaddr), 0);
        chk("rst_awlen", DW'(awlen), 0);
        chk("rst_ready", DW'(ready), 0);
        chk("rst_error", DW'(error), 0);
        chk("rst_idle", DW'(idle), 1);
        chk("awsize", DW'(awsize), 5);
        chk("awburst", DW'(awburst), 1);
        chk("awcache", DW'(awcache), 3);
        rst = 1'b1;
        @(negedge clk);

        // 16 contiguous beats from 0x1000: a single full burst.
        new_group(30'h1000, 16); model_group(); drive_range(0, 16, 0); end_timeout();
        chk("idle_after_b", DW'(idle), 1);

        // 20 contiguous beats: 16 + 4, the second closed by timeout.
        new_group(30'h2000, 20); model_group(); drive_range(0, 20, 0);
        valid = 1'b0; n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!awvalid && n < 200);
        chk("timeout_cycles", DW'(n), DW'(TO));
        wait_idle();

        // Address discontinuity: 0x400 held with ready low.
        new_group(30'h0, 3); g_a.push_back(30'h400); g_d.push_back(rnd_data()); g_s.push_back(32'hFFFF_FFFF);
        model_group(); drive_range(0, 3, 0);
        addr = 30'h400; #1;
        chk("ready_noncontig", DW'(ready), 0);
        drive_range(3, 4, 0); end_timeout();

        // 4 KB boundary split.
        new_group(30'hFC0, 4); model_group(); drive_range(0, 4, 0); end_timeout();

        // Delayed awready and toggling wready.
        aw_delay = 5; w_mode = 2;
        new_group(30'h3000, 12); model_group(); drive_range(0, 12, 0); end_timeout();
        w_mode = 1;
        new_group(30'h5020, 9); model_group(); drive_range(0, 9, 2); end_flush();
        aw_delay = 0; w_mode = 0;

        // Error response, sticky across a flushed burst, then cleared.
        bresp_next = 2'b10;
        new_group(30'h6000, 2); model_group(); drive_range(0, 2, 0); end_timeout();
        chk("error_set", DW'(error), 1);
        new_group(30'h7000, 3); model_group(); drive_range(0, 3, 0);
        valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        chk("flush_awvalid", DW'(awvalid), 1);
        chk("flush_awlen", DW'(awlen), 2);
        wait_idle();
        chk("error_sticky", DW'(error), 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("error_cleared", DW'(error), 0);

        // Randomized groups with jumps, gaps and random slave timing.
        for (int gi = 0; gi < 10; gi++) begin
            aw_delay = $urandom_range(0, 3);
            w_mode = $urandom_range(0, 2);
            g_a.delete(); g_d.delete(); g_s.delete();
            a = AW'($urandom_range(0, 15) * 4096 + $urandom_range(0, 127) * 32);
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 7) == 0) a = a + AW'($urandom_range(2, 9) * 32);
                g_a.push_back(a); g_d.push_back(rnd_data()); g_s.push_back($urandom);
                a = a + AW'(32);
            end
            model_group(); drive_range(0, n, 2);
            if ($urandom_range(0, 1) == 1) end_flush(); else end_timeout();
        end

        chk("bursts_left", DW'(bq.size()), 0);
        chk("beats_left", DW'(wq_d.size()), 0);
        foreach (mem_exp[k]) chk("mem", mem_act.exists(k) ? mem_act[k] : '0, mem_exp[k]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
